inter_to_axi3: RTL and testbench

INTER_TO_AXI3 -- requirements
Module: inter_to_axi3

---
 rtl/inter_to_axi3_pkg.sv | 29 ++
 rtl/inter_to_axi3.sv | 167 ++++++++++++++++
 tb/tb_inter_to_axi3.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inter_to_axi3_pkg.sv
// Shared AXI3 definitions for the internal-bus to AXI3 bridge: FSM states,
// fixed burst attributes, response codes and the timeout read pattern.
package inter_to_axi3_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RDATA
  } state_t;

  localparam logic [3:0]  AXI_LEN_SINGLE = 4'h0;
  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [3:0]  AXI_STRB_ALL   = 4'hF;

  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  // EXOKAY cannot occur on a non-exclusive access, so anything but OKAY is an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/inter_to_axi3.sv
// Single-beat bridge from a strobe/ack internal bus to an AXI3 master port.
// Optional response timeout: define INTER_TO_AXI3_TIMEOUT_EN.
module inter_to_axi3
  import inter_to_axi3_pkg::*;
#(
  parameter logic [31:0] BASEADDR = 32'h0,
  parameter int          TIMEOUT  = 1024,
  parameter logic [3:0]  AXI_ID   = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] bus_addr,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        bus_err,
  output logic        bus_busy,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  state_t      state, state_next;
  logic        aw_done, w_done;
  logic [31:0] addr_q, wdata_q;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        accept, expire;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign b_hs   = bvalid && bready;
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign accept = (state == IDLE) && (bus_wr || bus_rd);

`ifdef INTER_TO_AXI3_TIMEOUT_EN
  logic [15:0] timer;

  always_ff @(posedge clk) begin
    if (reset || state == IDLE) timer <= '0;
    else                        timer <= timer + 16'd1;
  end

  // Firing at TIMEOUT-2 lands bus_ack exactly TIMEOUT cycles after the request.
  assign expire = (state != IDLE) && (timer == 16'(TIMEOUT - 2));
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT < 2);
  assign expire     = 1'b0;
`endif

  // Single-beat bursts make rlast redundant; the R handshake alone ends a read.
  logic unused_rlast;
  assign unused_rlast = rlast;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus_wr) state_next = WRITE;
               else if (bus_rd) state_next = READ;
      WRITE:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WRESP;
      WRESP:   if (b_hs) state_next = IDLE;
      READ:    if (ar_hs) state_next = RDATA;
      RDATA:   if (r_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A response arriving in the expiry cycle still completes normally.
    if (expire && !b_hs && !r_hs) state_next = IDLE;
  end

  always_comb begin
    awvalid  = (state == WRITE) && !aw_done;
    wvalid   = (state == WRITE) && !w_done;
    arvalid  = (state == READ);
    bready   = (state == WRESP);
    rready   = (state == RDATA);
    bus_busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus_ack   <= 1'b0;
      bus_err   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack <= 1'b0;
      bus_err <= 1'b0;
      if (state == IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (accept) addr_q <= BASEADDR + {bus_addr, 2'b00};
      if (accept && bus_wr) wdata_q <= bus_wdata;
      if (b_hs) begin
        bus_ack <= 1'b1;
        bus_err <= resp_is_err(bresp);
      end else if (r_hs) begin
        bus_ack   <= 1'b1;
        bus_err   <= resp_is_err(rresp);
        bus_rdata <= rdata;
      end else if (expire) begin
        bus_ack <= 1'b1;
        bus_err <= 1'b1;
        if (state == READ || state == RDATA) bus_rdata <= TIMEOUT_RDATA;
      end
    end
  end

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = AXI_SIZE_4B;
  assign awburst = AXI_BURST_INCR;
  assign wid     = AXI_ID;
  assign wdata   = wdata_q;
  assign wstrb   = AXI_STRB_ALL;
  assign wlast   = 1'b1;
  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;

endmodule

// File: tb/tb_inter_to_axi3.sv
// Bench for inter_to_axi3: delay-programmable AXI3 slave, vector table,
// corner-case sequences and randomized traffic against a latency/response model.
module tb_inter_to_axi3;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          TO   = 16;
  localparam logic [3:0]  ID   = 4'h5;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] bus_addr;
  logic        bus_wr, bus_rd;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack, bus_err, bus_busy;
  logic [3:0]  awid, awlen, wid, wstrb, arid, arlen;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  inter_to_axi3 #(.BASEADDR(BASE), .TIMEOUT(TO), .AXI_ID(ID)) dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .bus_busy(bus_busy), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready), .wid(wid), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready), .bresp(bresp),
    .bvalid(bvalid), .bready(bready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- AXI3 slave model (acts on falling edges) ----------------
  int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;

  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit          aw_got, w_got, ar_got;
  logic        p_awvalid, p_wvalid, p_arvalid, p_bready, p_rready;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  int          aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, stab_err = 0, const_err = 0;

  task automatic slave_clear();
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
    rvalid = 0; rresp = 0; rdata = 0; rlast = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; ar_got = 0;
    p_awvalid = 0; p_wvalid = 0; p_arvalid = 0; p_bready = 0; p_rready = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0;
  endtask

  task automatic slave_step();
    if (reset) begin
      slave_clear();
      return;
    end
    // Handshakes that completed on the rising edge just passed.
    if (p_awvalid && awready) begin
      aw_got = 1; aw_hs_n++; cap_awaddr = p_awaddr;
      if (awid !== ID || awlen !== 4'h0 || awsize !== 3'b010 || awburst !== 2'b01) const_err++;
    end
    if (p_wvalid && wready) begin
      w_got = 1; w_hs_n++; cap_wdata = p_wdata;
      if (wid !== ID || wstrb !== 4'hF || wlast !== 1'b1) const_err++;
    end
    if (p_arvalid && arready) begin
      ar_got = 1; ar_hs_n++; cap_araddr = p_araddr;
      if (arid !== ID || arlen !== 4'h0 || arsize !== 3'b010 || arburst !== 2'b01) const_err++;
    end
    if (p_awvalid && awvalid && awaddr !== p_awaddr) stab_err++;
    if (p_wvalid && wvalid && wdata !== p_wdata) stab_err++;
    if (p_arvalid && arvalid && araddr !== p_araddr) stab_err++;

    if (bvalid && p_bready) begin
      bvalid = 0; aw_got = 0; w_got = 0; b_cnt = 0;
    end else if (aw_got && w_got && !bvalid) begin
      if (b_cnt >= b_dly) begin bvalid = 1; bresp = cfg_bresp; end
      b_cnt++;
    end
    if (rvalid && p_rready) begin
      rvalid = 0; rlast = 0; ar_got = 0; r_cnt = 0;
    end else if (ar_got && !rvalid) begin
      if (r_cnt >= r_dly) begin rvalid = 1; rlast = 1; rresp = cfg_rresp; rdata = cfg_rdata; end
      r_cnt++;
    end

    if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
    else begin awready = 0; aw_cnt = 0; end
    if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
    else begin wready = 0; w_cnt = 0; end
    if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end
    else begin arready = 0; ar_cnt = 0; end

    p_awvalid = awvalid; p_wvalid = wvalid; p_arvalid = arvalid;
    p_bready = bready; p_rready = rready;
    p_awaddr = awaddr; p_wdata = wdata; p_araddr = araddr;
  endtask

  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      slave_step();
    end
  end

  // ---------------- Stimulus helpers ----------------
  typedef struct {
    bit          wr;
    bit          rd;
    logic [29:0] addr;
    logic [31:0] wdat;
    int          d0, d1, d2;   // write: aw, w, b delays; read: ar, r delays
    logic [1:0]  resp;
    logic [31:0] sdata;        // slave read data
    logic [31:0] exp_addr;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic check_reset_state(input string name);
    check({name, " ctrl outputs"},
          32'({awvalid, wvalid, arvalid, bready, rready, bus_ack, bus_err, bus_busy}), 32'h0);
    check({name, " bus_rdata"}, bus_rdata, 32'h0);
  endtask

  // Starts on a falling edge; returns one cycle after bus_ack.
  task automatic run_txn(input string name, input bit wr, input bit rd, input logic [29:0] a,
                         input logic [31:0] d, output int lat, output logic err,
                         output logic [31:0] rd_out);
    bus_wr = wr; bus_rd = rd; bus_addr = a; bus_wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus_wr = 0; bus_rd = 0;
    end while (bus_ack !== 1'b1 && lat < 200);
    err = bus_err;
    rd_out = bus_rdata;
    @(negedge clk);
    check({name, " ack single pulse"}, 32'(bus_ack), 32'h0);
  endtask

  task automatic do_vec(input string name, input vec_t v);
    int lat, aw0, w0, ar0;
    logic err;
    logic [31:0] rdv;
    aw_dly = v.wr ? v.d0 : 0; w_dly = v.d1; b_dly = v.d2;
    ar_dly = v.wr ? 0 : v.d0; r_dly = v.d1;
    cfg_bresp = v.resp; cfg_rresp = v.resp; cfg_rdata = v.sdata;
    cap_awaddr = 'x; cap_wdata = 'x; cap_araddr = 'x;
    aw0 = aw_hs_n; w0 = w_hs_n; ar0 = ar_hs_n;
    run_txn(name, v.wr, v.rd, v.addr, v.wdat, lat, err, rdv);
    check($sformatf("%s latency", name), 32'(lat), 32'(v.exp_lat));
    check($sformatf("%s bus_err", name), 32'(err), 32'(v.exp_err));
    check($sformatf("%s bus_rdata", name), rdv, v.exp_rdata);
    if (v.wr) begin
      check($sformatf("%s awaddr", name), cap_awaddr, v.exp_addr);
      check($sformatf("%s wdata", name), cap_wdata, v.wdat);
      check($sformatf("%s aw/w/ar handshakes", name),
            32'({8'(aw_hs_n - aw0), 8'(w_hs_n - w0), 8'(ar_hs_n - ar0)}), 32'h010100);
    end else begin
      check($sformatf("%s araddr", name), cap_araddr, v.exp_addr);
      check($sformatf("%s aw/w/ar handshakes", name),
            32'({8'(aw_hs_n - aw0), 8'(w_hs_n - w0), 8'(ar_hs_n - ar0)}), 32'h000001);
    end
  endtask

  task automatic count_acks(input int cycles, output int acks);
    acks = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus_ack === 1'b1) acks++;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[8];

  initial begin
    int acks, aw0, ar0, lat;
    logic err;
    logic [31:0] rdv, model_rdata;
    bit bounded;

    //        wr rd addr          wdat           d0 d1 d2 resp  sdata         exp_addr      lat err exp_rdata
    vecs[0] = '{1, 0, 30'h10,       32'h0B0BADED, 0, 0, 0, 2'b00, 32'h0,        32'h4000_0040, 3, 0, 32'h0};
    vecs[1] = '{0, 1, 30'h3,        32'h0,        5, 0, 0, 2'b00, 32'h12345678, 32'h4000_000C, 8, 0, 32'h12345678};
    vecs[2] = '{1, 0, 30'h100,      32'h55AA_00FF, 0, 4, 0, 2'b00, 32'h0,       32'h4000_0400, 7, 0, 32'h12345678};
    vecs[3] = '{0, 1, 30'h20,       32'h0,        0, 0, 0, 2'b10, 32'hCAFEF00D, 32'h4000_0080, 3, 1, 32'hCAFEF00D};
    vecs[4] = '{0, 1, 30'h3FFFFFFF, 32'h0,        0, 2, 0, 2'b00, 32'hA5A5A5A5, 32'h3FFF_FFFC, 5, 0, 32'hA5A5A5A5};
    vecs[5] = '{1, 0, 30'h0,        32'h1,        2, 1, 3, 2'b11, 32'h0,        32'h4000_0000, 8, 1, 32'hA5A5A5A5};
    vecs[6] = '{1, 1, 30'h7,        32'h77,       1, 0, 1, 2'b00, 32'h0,        32'h4000_001C, 5, 0, 32'hA5A5A5A5};
    vecs[7] = '{1, 0, 30'h2AAA_AAAA, 32'hFFFF_0000, 3, 3, 0, 2'b10, 32'h0,      32'hEAAA_AAA8, 6, 1, 32'hA5A5A5A5};

    bus_wr = 0; bus_rd = 0; bus_addr = 0; bus_wdata = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    cfg_bresp = 0; cfg_rresp = 0; cfg_rdata = 0;
    do_reset();

    // Table vectors run back-to-back: each starts the cycle after the previous ack.
    for (int i = 0; i < 8; i++) do_vec($sformatf("vec%0d", i), vecs[i]);

    // awready four cycles ahead of wready: awvalid drops alone, one ack.
    aw_dly = 0; w_dly = 4; b_dly = 0; cfg_bresp = 0;
    bus_wr = 1; bus_addr = 30'h44; bus_wdata = 32'h1234;
    @(negedge clk); bus_wr = 0;
    check("split aw/w cycle1 valids", 32'({awvalid, wvalid}), 32'h3);
    @(negedge clk);
    check("split aw/w cycle2 valids", 32'({awvalid, wvalid}), 32'h1);
    count_acks(15, acks);
    check("split aw/w ack count", 32'(acks), 32'h1);

    // Read strobe while busy is ignored.
    aw_dly = 0; w_dly = 0; b_dly = 4;
    aw0 = aw_hs_n; ar0 = ar_hs_n;
    bus_wr = 1; bus_addr = 30'h8;
    @(negedge clk); bus_wr = 0;
    @(negedge clk);
    check("busy during write", 32'(bus_busy), 32'h1);
    bus_rd = 1; bus_addr = 30'h99;
    @(negedge clk); bus_rd = 0;
    count_acks(15, acks);
    check("busy-ignored ack count", 32'(acks), 32'h1);
    check("busy-ignored handshakes", 32'({8'(aw_hs_n - aw0), 8'(ar_hs_n - ar0)}), 32'h0100);

    // Reset while waiting for the write response.
    b_dly = 6;
    bus_wr = 1; bus_addr = 30'h5;
    bounded = 0;
    for (int i = 0; i < 10 && !bounded; i++) begin
      @(negedge clk); bus_wr = 0;
      if (bready === 1'b1) bounded = 1;
    end
    check("reached WRESP", 32'(bounded), 32'h1);
    reset = 1;
    @(negedge clk);
    check_reset_state("reset in WRESP");
    @(negedge clk);
    reset = 0;
    count_acks(12, acks);
    check("no ack after abort", 32'(acks), 32'h0);

`ifdef INTER_TO_AXI3_TIMEOUT_EN
    ar_dly = 1_000_000; r_dly = 0;
    run_txn("timeout read", 0, 1, 30'h9, 32'h0, lat, err, rdv);
    check("timeout latency", 32'(lat), 32'(TO));
    check("timeout bus_err", 32'(err), 32'h1);
    check("timeout bus_rdata", rdv, 32'hDEADBEEF);
    check("timeout valids low", 32'({arvalid, bus_busy}), 32'h0);
    ar_dly = 0;
`endif

    // Randomized traffic checked against a latency/response model.
    do_reset();
    model_rdata = 32'h0;
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      int m;
      v.wr    = 1'($urandom_range(0, 1));
      v.rd    = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      v.addr  = 30'($urandom);
      v.wdat  = $urandom;
      v.d0    = $urandom_range(0, 4);
      v.d1    = $urandom_range(0, 4);
      v.d2    = $urandom_range(0, 4);
      v.resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v.sdata = $urandom;
      v.exp_addr = BASE + {v.addr, 2'b00};
      m = (v.d0 > v.d1) ? v.d0 : v.d1;
      v.exp_lat = v.wr ? 3 + m + v.d2 : 3 + v.d0 + v.d1;
      v.exp_err = (v.resp != 2'b00);
      if (!v.wr) model_rdata = v.sdata;
`ifdef INTER_TO_AXI3_TIMEOUT_EN
      if (v.exp_lat > TO) begin
        v.exp_lat = TO;
        v.exp_err = 1;
        if (!v.wr) model_rdata = 32'hDEADBEEF;
      end
`endif
      v.exp_rdata = model_rdata;
      do_vec($sformatf("rand%0d", n), v);
    end

    check("address/data stable while valid", 32'(stab_err), 32'h0);
    check("AXI constant fields", 32'(const_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
